// File: rtl/reg_write_arbiter_if.sv
// Bus between pipeline-stage writers and reg_write_arbiter: requests, write data, grant and bank write port.
// The lock vector exists only when ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]       lock;
`endif
    logic [NUM_REQ-1:0]       gnt;
    logic                     reg_en;
    logic [WIDTH-1:0]         reg_d;
    logic [IDX_W-1:0]         gnt_idx;

`ifdef ARB_LOCK_EN
    modport master (
        output req, wdata, lock,
        input  gnt, reg_en, reg_d, gnt_idx
    );

    modport slave (
        input  req, wdata, lock,
        output gnt, reg_en, reg_d, gnt_idx
    );
`else
    modport master (
        output req, wdata,
        input  gnt, reg_en, reg_d, gnt_idx
    );

    modport slave (
        input  req, wdata,
        output gnt, reg_en, reg_d, gnt_idx
    );
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one write port of a WIDTH-bit register bank among NUM_REQ writers.
// Optional grant locking (up to MAX_LOCK consecutive grants) is enabled by defining ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    reg_write_arbiter_if.slave      bus
);
    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 1) begin : g_bad_cfg
        $error("reg_write_arbiter: unsupported NUM_REQ or MAX_LOCK");
    end

    logic [NUM_REQ-1:0] req_s;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   ptr_q,     ptr_d;
    logic               found_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic [IDX_W-1:0]   rr_ptr_s;
    logic               hold_s;
    logic               reg_en_s;
    logic [WIDTH-1:0]   reg_d_s;

    assign req_s = bus.req;

`ifdef ARB_LOCK_EN
    localparam int                LCNT_W   = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK - 1);

    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // A locked transfer keeps the grant until the run reaches MAX_LOCK grants.
    always_comb begin
        hold_s = 1'b0;
        if ((|(req_s & gnt_q & bus.lock)) && (lock_cnt_q != LCNT_MAX)) begin
            hold_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
    end

    // Lock run length: counts held grants, clears whenever the grant is re-arbitrated.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (hold_s) begin
            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
        end else begin
            lock_cnt_d = {LCNT_W{1'b0}};
        end
    end

    // Lock run-length register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt_q <= {LCNT_W{1'b0}};
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign hold_s = 1'b0;
`endif

    // Round-robin scan starting at ptr; the first asserted request wins.
    always_comb begin
        found_s   = 1'b0;
        win_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            int  cand;
            logic hit;
            cand      = (int'(ptr_q) + k) % NUM_REQ;
            hit       = !found_s && req_s[cand];
            win_idx_s = hit ? IDX_W'(cand) : win_idx_s;
            found_s   = found_s | req_s[cand];
        end
    end

    // The winner ranks last next time: pointer moves just past it, wrapping at NUM_REQ-1.
    always_comb begin
        rr_ptr_s = {IDX_W{1'b0}};
        if (win_idx_s == LAST_IDX) begin
            rr_ptr_s = {IDX_W{1'b0}};
        end else begin
            rr_ptr_s = win_idx_s + IDX_W'(1);
        end
    end

    // Next grant state: hold on lock, otherwise re-arbitrate from the current requests.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        if (hold_s) begin
            gnt_d     = gnt_q;
            gnt_idx_d = gnt_idx_q;
            ptr_d     = ptr_q;
        end else if (found_s) begin
            gnt_d     = ONE_HOT0 << win_idx_s;
            gnt_idx_d = win_idx_s;
            ptr_d     = rr_ptr_s;
        end else begin
            gnt_d     = {NUM_REQ{1'b0}};
            gnt_idx_d = {IDX_W{1'b0}};
            ptr_d     = ptr_q;
        end
    end

    // Grant, grant index and priority pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q     <= {NUM_REQ{1'b0}};
            gnt_idx_q <= {IDX_W{1'b0}};
            ptr_q     <= {IDX_W{1'b0}};
        end else begin
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    // Bank write port; gated by reset so nothing can commit while it is held low.
    always_comb begin
        reg_en_s = 1'b0;
        reg_d_s  = {WIDTH{1'b0}};
        if (reset && (|gnt_q)) begin
            reg_en_s = |(req_s & gnt_q);
            reg_d_s  = bus.wdata[int'(gnt_idx_q) * WIDTH +: WIDTH];
        end else begin
            reg_en_s = 1'b0;
            reg_d_s  = {WIDTH{1'b0}};
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.reg_en  = reg_en_s;
    assign bus.reg_d   = reg_d_s;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter with a behavioural register bank on the write port.
// Define ARB_LOCK_EN when compiling to exercise grant locking.
module tb_reg_write_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    logic [W-1:0] bank_q = 16'h0000;

    reg_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_LOCK(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared register bank written through the arbiter's port.
    always @(posedge clk) begin
        if (bus.reg_en) bank_q <= bus.reg_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        bus.req   = 4'b0000;
        bus.wdata = 64'h0;
`ifdef ARB_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
`ifdef ARB_LOCK_EN
        bus.lock  = 4'b0000;
`endif
        tick();
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.reg_en !== 1'b0) begin fails++; $display("FAIL reset_reg_en: got %b expected 0", bus.reg_en); end
        checks++; if (bus.reg_d !== 16'h0000) begin fails++; $display("FAIL reset_reg_d: got %h expected 0000", bus.reg_d); end
        checks++; if (bus.gnt_idx !== 2'd0) begin fails++; $display("FAIL reset_gnt_idx: got %0d expected 0", bus.gnt_idx); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL first_gnt: got %b expected 0001", bus.gnt); end
        checks++; if (bus.reg_d !== 16'h1111) begin fails++; $display("FAIL first_reg_d: got %h expected 1111", bus.reg_d); end
        bus.req = 4'b0000;
    endtask

    task automatic test_single_write();
        apply_reset();
        bus.req              = 4'b0100;
        bus.wdata[2*W +: W]  = 16'hA5A5;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL sw_gnt_n: got %b expected 0000", bus.gnt); end
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL sw_gnt_n1: got %b expected 0100", bus.gnt); end
        checks++; if (bus.gnt_idx !== 2'd2) begin fails++; $display("FAIL sw_gnt_idx: got %0d expected 2", bus.gnt_idx); end
        checks++; if (bus.reg_en !== 1'b1 || bus.reg_d !== 16'hA5A5) begin fails++; $display("FAIL sw_port: got en=%b d=%h expected en=1 d=a5a5", bus.reg_en, bus.reg_d); end
        tick();
        bus.req = 4'b0000;
        #1;
        checks++; if (bank_q !== 16'hA5A5) begin fails++; $display("FAIL sw_bank: got %h expected a5a5", bank_q); end
        checks++; if (bus.reg_en !== 1'b0) begin fails++; $display("FAIL sw_drop_en: got %b expected 0", bus.reg_en); end
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL sw_gnt_idle: got %b expected 0000", bus.gnt); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_gnt [8];
        logic [W-1:0] exp_d   [8];
        int           writes;
        int           per [N];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_d   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        writes  = 0;
        for (int i = 0; i < N; i++) per[i] = 0;
        apply_reset();
        bus.wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req   = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++; if (bus.gnt !== exp_gnt[c] || bus.reg_d !== exp_d[c]) begin fails++; $display("FAIL fair_cycle%0d: got gnt=%b d=%h expected gnt=%b d=%h", c, bus.gnt, bus.reg_d, exp_gnt[c], exp_d[c]); end
            if (bus.reg_en === 1'b1) begin
                writes++;
                per[bus.gnt_idx]++;
            end
        end
        tick();
        bus.req = 4'b0000;
        checks++; if (writes != 8) begin fails++; $display("FAIL fair_writes: got %0d expected 8", writes); end
        for (int i = 0; i < N; i++) begin
            checks++; if (per[i] != 2) begin fails++; $display("FAIL fair_per%0d: got %0d expected 2", i, per[i]); end
        end
        checks++; if (bank_q !== 16'h4444) begin fails++; $display("FAIL fair_bank: got %h expected 4444", bank_q); end
        tick();
    endtask

    task automatic test_idle_slot();
        apply_reset();
        bus.wdata = {16'h0000, 16'hBEEF, 16'h5555, 16'h1234};
        bus.req   = 4'b0001;
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin fails++; $display("FAIL idle_g0: got %b expected 0001", bus.gnt); end
        bus.req = 4'b0011;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL idle_g1: got %b expected 0010", bus.gnt); end
        checks++; if (bank_q !== 16'h1234) begin fails++; $display("FAIL idle_bank_w: got %h expected 1234", bank_q); end
        bus.req = 4'b0100;
        #1;
        checks++; if (bus.reg_en !== 1'b0) begin fails++; $display("FAIL idle_en: got %b expected 0", bus.reg_en); end
        tick();
        checks++; if (bank_q !== 16'h1234) begin fails++; $display("FAIL idle_bank_hold: got %h expected 1234", bank_q); end
        checks++; if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2) begin fails++; $display("FAIL idle_move: got gnt=%b idx=%0d expected 0100 idx=2", bus.gnt, bus.gnt_idx); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.wdata = {16'h0000, 16'h0000, 16'hCAFE, 16'h0F0F};
        bus.req   = 4'b0011;
        tick();
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL ar_pre_gnt: got %b expected 0010", bus.gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000 || bus.reg_en !== 1'b0) begin fails++; $display("FAIL ar_now: got gnt=%b en=%b expected 0000 en=0", bus.gnt, bus.reg_en); end
        checks++; if (bus.reg_d !== 16'h0000 || bus.gnt_idx !== 2'd0) begin fails++; $display("FAIL ar_port: got d=%h idx=%0d expected 0000 idx=0", bus.reg_d, bus.gnt_idx); end
        tick();
        checks++; if (bank_q !== 16'h0F0F) begin fails++; $display("FAIL ar_bank: got %h expected 0f0f", bank_q); end
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.wdata = {16'h7001, 16'h0000, 16'h0000, 16'h0A0A};
        bus.req   = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus.gnt !== 4'b1000 || bus.reg_en !== 1'b1) begin fails++; $display("FAIL b2b_cycle%0d: got gnt=%b en=%b expected 1000 en=1", c, bus.gnt, bus.reg_en); end
        end
        bus.req = 4'b1001;
        tick();
        checks++; if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin fails++; $display("FAIL b2b_wrap: got gnt=%b idx=%0d expected 0001 idx=0", bus.gnt, bus.gnt_idx); end
        checks++; if (bank_q !== 16'h7001) begin fails++; $display("FAIL b2b_bank: got %h expected 7001", bank_q); end
        tick();
        checks++; if (bus.gnt !== 4'b1000) begin fails++; $display("FAIL b2b_rr: got %b expected 1000", bus.gnt); end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_lock();
        logic [N-1:0] exp_gnt [9];
`ifdef ARB_LOCK_EN
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        exp_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
        apply_reset();
        bus.wdata = {16'h0000, 16'h0000, 16'hBB00, 16'hAA00};
        bus.req   = 4'b0011;
`ifdef ARB_LOCK_EN
        bus.lock  = 4'b0001;
`endif
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++; if (bus.gnt !== exp_gnt[c]) begin fails++; $display("FAIL lock_cycle%0d: got %b expected %b", c, bus.gnt, exp_gnt[c]); end
        end
        bus.req = 4'b0000;
`ifdef ARB_LOCK_EN
        bus.lock = 4'b0000;
`endif
        tick();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        test_reset();
        test_single_write();
        test_fairness();
        test_idle_slot();
        test_async_reset();
        test_back_to_back();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
